cordic_polar2rect: RTL and testbench

CORDIC_POLAR2RECT -- requirements
Module: cordic_polar2rect

---
 rtl/cordic_polar2rect.sv | 230 +++++++++++++++++++++++
 tb/tb_cordic_polar2rect.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_polar2rect.sv
// Iterative CORDIC polar-to-rectangular converter: one micro-rotation per clock,
// quadrant pre-rotation on operand capture, saturated x/y results with a done pulse.
module cordic_polar2rect #(
   parameter int INT_WIDTH     = 32,
   parameter int ITERATIONS    = 16,
   parameter int MAG_FRAC_BITS = 14
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic signed [INT_WIDTH-1:0] magnitude_in,
   input  logic signed [INT_WIDTH-1:0] phase_in,
   output logic                        busy,
   output logic                        done,
   output logic signed [INT_WIDTH-1:0] x_out,
   output logic signed [INT_WIDTH-1:0] y_out,
   output logic [1:0]                  state_dbg
);

   // Phase is radians scaled by 2^28, so the word must hold at least +/-pi at that scale.
   if (ITERATIONS < 8 || ITERATIONS > 24 || INT_WIDTH < 32 || MAG_FRAC_BITS >= INT_WIDTH) begin : g_bad_params
      $error("cordic_polar2rect: unsupported parameter set");
   end

   localparam int XW    = INT_WIDTH + 2;
   localparam int CNT_W = 5;

   localparam logic signed [INT_WIDTH-1:0] PI_C  = INT_WIDTH'(843314857);
   localparam logic signed [INT_WIDTH-1:0] PI2_C = INT_WIDTH'(421657428);
   localparam logic [15:0]                 KC    = 16'd39797;
   localparam logic [CNT_W-1:0]            LAST_ITER = CNT_W'(ITERATIONS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROTATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Handshake: start is a request that is honoured only while idle (busy=0); the
   // request is accepted on the sampling edge, busy rises the next cycle, and the
   // single-cycle done pulse marks x_out/y_out valid. busy and done are never both high.

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              iter_q, iter_d;
   logic signed [XW-1:0]          x_q, x_d;
   logic signed [XW-1:0]          y_q, y_d;
   logic signed [INT_WIDTH-1:0]   z_q, z_d;
   logic signed [INT_WIDTH-1:0]   x_out_q, x_out_d;
   logic signed [INT_WIDTH-1:0]   y_out_q, y_out_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

   function automatic logic [31:0] atan_lut(input logic [CNT_W-1:0] i);
      logic [31:0] v;
      case (i)
         5'd0:    v = 32'd210828714;
         5'd1:    v = 32'd124459457;
         5'd2:    v = 32'd65760959;
         5'd3:    v = 32'd33381290;
         5'd4:    v = 32'd16755422;
         5'd5:    v = 32'd8385879;
         5'd6:    v = 32'd4193963;
         5'd7:    v = 32'd2097109;
         5'd8:    v = 32'd1048571;
         5'd9:    v = 32'd524287;
         5'd10:   v = 32'd262144;
         5'd11:   v = 32'd131072;
         5'd12:   v = 32'd65536;
         5'd13:   v = 32'd32768;
         5'd14:   v = 32'd16384;
         5'd15:   v = 32'd8192;
         5'd16:   v = 32'd4096;
         5'd17:   v = 32'd2048;
         5'd18:   v = 32'd1024;
         5'd19:   v = 32'd512;
         5'd20:   v = 32'd256;
         5'd21:   v = 32'd128;
         5'd22:   v = 32'd64;
         5'd23:   v = 32'd32;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   // The two guard bits absorb CORDIC gain overshoot; clip back to the port width.
   function automatic logic signed [INT_WIDTH-1:0] sat_w(input logic signed [XW-1:0] v);
      logic [2:0] top;
      logic signed [INT_WIDTH-1:0] r;
      top = v[XW-1:INT_WIDTH-1];
      if (top == 3'b000 || top == 3'b111) begin
         r = v[INT_WIDTH-1:0];
      end else if (v[XW-1]) begin
         r = {1'b1, {(INT_WIDTH-1){1'b0}}};
      end else begin
         r = {1'b0, {(INT_WIDTH-1){1'b1}}};
      end
      return r;
   endfunction

   // Operand conditioning and quadrant pre-rotation, evaluated on the capture edge.
   logic signed [INT_WIDTH-1:0] mag_clamp;
   logic signed [INT_WIDTH-1:0] phase_sat;
   logic [INT_WIDTH+15:0]       prod;
   logic signed [XW-1:0]        x0;
   logic signed [XW-1:0]        x_init, y_init;
   logic signed [INT_WIDTH-1:0] z_init;

   always_comb begin
      mag_clamp = magnitude_in[INT_WIDTH-1] ? '0 : magnitude_in;
      if (phase_in > PI_C) begin
         phase_sat = PI_C;
      end else if (phase_in < -PI_C) begin
         phase_sat = -PI_C;
      end else begin
         phase_sat = phase_in;
      end
      prod = (INT_WIDTH+16)'(mag_clamp) * (INT_WIDTH+16)'(KC);
      x0   = XW'(prod >> 16);
      if (phase_sat > PI2_C) begin
         x_init = '0;
         y_init = x0;
         z_init = phase_sat - PI2_C;
      end else if (phase_sat < -PI2_C) begin
         x_init = '0;
         y_init = -x0;
         z_init = phase_sat + PI2_C;
      end else begin
         x_init = x0;
         y_init = '0;
         z_init = phase_sat;
      end
   end

   // One micro-rotation, steered by the sign of the residual angle.
   logic signed [XW-1:0]        x_sh, y_sh;
   logic signed [INT_WIDTH-1:0] atan_z;
   logic signed [XW-1:0]        x_rot, y_rot;
   logic signed [INT_WIDTH-1:0] z_rot;

   always_comb begin
      x_sh   = x_q >>> iter_q;
      y_sh   = y_q >>> iter_q;
      atan_z = INT_WIDTH'(atan_lut(iter_q));
      if (!z_q[INT_WIDTH-1]) begin
         x_rot = x_q - y_sh;
         y_rot = y_q + x_sh;
         z_rot = z_q - atan_z;
      end else begin
         x_rot = x_q + y_sh;
         y_rot = y_q - x_sh;
         z_rot = z_q + atan_z;
      end
   end

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ROTATE;
               iter_d  = '0;
               x_d     = x_init;
               y_d     = y_init;
               z_d     = z_init;
               busy_d  = 1'b1;
            end
         end
         S_ROTATE: begin
            x_d    = x_rot;
            y_d    = y_rot;
            z_d    = z_rot;
            iter_d = iter_q + 1'b1;
            if (iter_q == LAST_ITER) begin
               state_d = S_DONE;
               iter_d  = '0;
            end
         end
         S_DONE: begin
            x_out_d = sat_w(x_q);
            y_out_d = sat_w(y_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         x_out_q <= '0;
         y_out_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign x_out     = x_out_q;
   assign y_out     = y_out_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_cordic_polar2rect.sv
// Directed bench for cordic_polar2rect: hand-computed polar vectors, boundaries,
// ignored mid-flight start, reset abort and a magnitude/phase round trip.
module tb_cordic_polar2rect;

   localparam int W = 32;
   localparam longint ONE   = 16384;      // 1.0 at 14 fractional bits
   localparam longint TWO   = 32768;
   localparam longint M1000 = 16384000;
   localparam longint M707  = 11585238;   // 707.1068
   localparam longint M500  = 8192000;
   localparam longint M353  = 5792619;    // 353.5534
   localparam longint P45   = 210828714;
   localparam longint P135  = 632486143;
   localparam longint PI_S  = 843314857;
   localparam longint RT_MAG = 23170475;  // 1414.2136

   // Clock/reset block
   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic signed [W-1:0] magnitude_in;
   logic signed [W-1:0] phase_in;
   logic                busy;
   logic                done;
   logic signed [W-1:0] x_out;
   logic signed [W-1:0] y_out;
   logic [1:0]          state_dbg;

   always #5 clk = ~clk;

   cordic_polar2rect #(
      .INT_WIDTH     (W),
      .ITERATIONS    (16),
      .MAG_FRAC_BITS (14)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .magnitude_in (magnitude_in),
      .phase_in     (phase_in),
      .busy         (busy),
      .done         (done),
      .x_out        (x_out),
      .y_out        (y_out),
      .state_dbg    (state_dbg)
   );

   int checks   = 0;
   int failures = 0;
   int edges;
   int pulses;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input longint obs, input longint exp,
                             input longint tol);
      longint d;
      logic   ok;
      d = obs - exp;
      if (d < 0) d = -d;
      ok = (d <= tol);
      checks++;
      assert (ok === 1'b1) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
      end
   endtask

   // Driver: issue one request from IDLE and wait (bounded) for done.
   task automatic run_conv(input string tag, input longint mag, input longint ph);
      magnitude_in = W'(mag);
      phase_in     = W'(ph);
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_rise"}, busy, 1);
      edges = 0;
      while (done !== 1'b1 && edges < 60) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, "_latency"}, edges, 17);
      check({tag, "_busy_at_done"}, busy, 0);
   endtask

   task automatic expect_xy(input string tag, input longint ex, input longint ey,
                            input longint tol);
      check_near({tag, "_x"}, x_out, ex, tol);
      check_near({tag, "_y"}, y_out, ey, tol);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint ph_tab [4];
      longint ex_tab [4];
      longint ey_tab [4];
      ph_tab = '{P45, P135, -P135, -P45};
      ex_tab = '{M1000, -M1000, -M1000, M1000};
      ey_tab = '{M1000, M1000, -M1000, -M1000};

      rst_n        = 1'b0;
      start        = 1'b0;
      magnitude_in = '0;
      phase_in     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_x", x_out, 0);
      check("rst_y", y_out, 0);
      check("rst_state", state_dbg, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1000.0 at phase 0, then hold and single-cycle done
      run_conv("ph0", M1000, 0);
      expect_xy("ph0", M1000, 0, ONE);
      @(posedge clk);
      #1;
      check("ph0_done_one_cycle", done, 0);
      check_near("ph0_x_hold", x_out, M1000, ONE);

      // +/-45 and +/-135 degrees, issued back to back
      run_conv("p45", M1000, P45);
      expect_xy("p45", M707, M707, ONE);
      run_conv("p135", M1000, P135);
      expect_xy("p135", -M707, M707, ONE);
      run_conv("m135", M1000, -P135);
      expect_xy("m135", -M707, -M707, ONE);
      run_conv("m45", M1000, -P45);
      expect_xy("m45", M707, -M707, ONE);

      // Boundaries
      run_conv("pi", M1000, PI_S);
      expect_xy("pi", -M1000, 0, ONE);
      run_conv("ph_sat_pos", M1000, 64'h7FFF_FFFF);
      expect_xy("ph_sat_pos", -M1000, 0, ONE);
      run_conv("ph_sat_neg", M1000, -64'sd2147483648);
      expect_xy("ph_sat_neg", -M1000, 0, ONE);
      run_conv("mag_zero", 0, P45);
      expect_xy("mag_zero", 0, 0, 0);
      run_conv("mag_neg", -5000000, P45);
      expect_xy("mag_neg", 0, 0, 0);

      // start during ROTATE with different operands must be ignored
      magnitude_in = W'(M1000);
      phase_in     = '0;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         edges++;
      end
      magnitude_in = W'(M500);
      phase_in     = W'(P45);
      start        = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      start = 1'b0;
      while (done !== 1'b1 && edges < 60) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("ign_latency", edges, 17);
      expect_xy("ign", M1000, 0, ONE);
      pulses = 0;
      repeat (25) begin
         if (done === 1'b1) pulses++;
         @(posedge clk);
         #1;
      end
      check("ign_done_pulses", pulses, 1);
      check("ign_state_idle", state_dbg, 0);

      // Reset at iteration 8 aborts without done
      magnitude_in = W'(M500);
      phase_in     = W'(P45);
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("abort_state_rotate", state_dbg, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_x", x_out, 0);
      check("abort_state", state_dbg, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      check("abort_no_done", pulses, 0);
      run_conv("post_rst", M500, P45);
      expect_xy("post_rst", M353, M353, ONE);

      // Round trip from magnitude/phase of (+/-1000, +/-1000)
      for (int i = 0; i < 4; i++) begin
         run_conv($sformatf("rt%0d", i), RT_MAG, ph_tab[i]);
         expect_xy($sformatf("rt%0d", i), ex_tab[i], ey_tab[i], TWO);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
